fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the instruction rom.
- Owns the PC and drives the rom address; consumes the rom's registered read data one cycle later.
- Presents {pc, instr} to decode through a valid/ready handshake.
- Holds a 2-entry buffer so rom latency and decode stalls never lose or duplicate an instruction.
- Redirects from execute (branch/jump) flush all in-flight work.

---
 rtl/isa_types_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/isa_types_pkg.sv
// Shared ISA-level types for the fetch path: word width, instruction size,
// the {pc, instr} entry passed to decode and the fetch state encoding.
package isa_types_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small in-order FIFO of fetch entries between the rom return path and decode.
// Push and pop may happen in the same cycle; flush empties it and wins over push.
module fetch_buffer
    import isa_types_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_entry_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; flush clears everything including a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The issue rule upstream must never let a push land on a full buffer.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && !flush_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the rom address, captures the
// registered rom word one cycle later and presents {pc, instr} to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises out_fault instead of silently clearing the low bits).
module fetch_unit
    import isa_types_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_fault
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;

    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [XLEN-1:0]  redirect_aligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             fault_q, fault_d;
    logic [XLEN-1:0]  fault_pc_q, fault_pc_d;
`endif

    assign pop              = out_valid & out_ready;
    assign occupancy        = OCC_W'(buf_count) - OCC_W'(pop) + OCC_W'(inflight_q);
    assign issue            = (occupancy < OCC_W'(BUF_DEPTH)) && (state_q == RUN) && !redirect_valid;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign push_entry       = '{pc: req_pc_q, instr: rom_rdata};

    // Next PC / request tracking; a redirect overrides any issue in the same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
`endif
        if (redirect_valid) begin
            pc_d = redirect_aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                state_d = RUN;
                fault_d = 1'b0;
            end
`else
            state_d = RUN;
`endif
        end else if (issue) begin
            pc_d       = pc_q + XLEN'(INSTR_BYTES);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    // PC, outstanding request and state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Fault flag and the raw misaligned target it reports.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end
`endif

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .flush_i      (redirect_valid),
        .push_i       (inflight_q),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (buf_head),
        .count_o      (buf_count)
    );

    assign rom_addr  = pc_q;
    assign out_valid = (buf_count != '0);
    assign out_instr = buf_head.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign out_pc    = fault_q ? fault_pc_q : buf_head.pc;
    assign out_fault = fault_q;
`else
    assign out_pc    = buf_head.pc;
    assign out_fault = 1'b0;
`endif

endmodule
